csr_trap_unit: RTL

- Machine-mode CSR file and trap sequencer for the pipelined RV32I core with exceptions and interrupts.
- Sits at the commit (MEM/WB) stage and consumes the decoder's CSR and exception controls: csr_wdata_sel, csr_wdata_op, invalid_instruction.
- Executes Zicsr read-modify-writes, takes synchronous exceptions and external/timer interrupts, and executes mret.
- Returns the redirect target and a pipeline flush to the fetch/hazard logic.

---
 rtl/csr_trap_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the RV32I commit stage.
// Handles Zicsr read-modify-write, synchronous exceptions, irqs, mret and the 64-bit counters.
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        csr_en,
  input  logic [11:0] csr_addr,
  input  logic        csr_wdata_sel,
  input  logic [1:0]  csr_wdata_op,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        invalid_instruction,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_taken
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic                   r_mie_b, r_mpie, r_meie, r_mtie;
  logic [31:2]            r_mtvec, r_mepc;
  logic [31:0]            r_mscratch, r_mcause;
  logic [63:0]            r_mcycle, r_minstret;
  logic [SYNC_STAGES-1:0] r_ext_sync, r_tmr_sync;

  logic        w_meip, w_mtip;
  logic [31:0] w_mstatus, w_mie, w_mip;
  logic [31:0] w_old, w_src, w_wval;
  logic        w_irq_ext, w_irq_tmr, w_trap, w_mret_go, w_we, w_retire;
  logic [31:0] w_cause;

  assign w_meip    = r_ext_sync[SYNC_STAGES-1];
  assign w_mtip    = r_tmr_sync[SYNC_STAGES-1];
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie_b, 3'b0};
  assign w_mie     = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip     = {20'b0, w_meip, 3'b0, w_mtip, 7'b0};

  always_comb begin
    w_old = 32'h0;
    case (csr_addr)
      A_MSTATUS:   w_old = w_mstatus;
      A_MIE:       w_old = w_mie;
      A_MTVEC:     w_old = {r_mtvec, 2'b00};
      A_MSCRATCH:  w_old = r_mscratch;
      A_MEPC:      w_old = {r_mepc, 2'b00};
      A_MCAUSE:    w_old = r_mcause;
      A_MIP:       w_old = w_mip;
      A_MCYCLE:    w_old = r_mcycle[31:0];
      A_MCYCLEH:   w_old = r_mcycle[63:32];
      A_MINSTRET:  w_old = r_minstret[31:0];
      A_MINSTRETH: w_old = r_minstret[63:32];
      default:     w_old = 32'h0;
    endcase
  end

  assign csr_rdata = w_old;
  assign w_src     = csr_wdata_sel ? {27'b0, zimm} : rs1_data;

  always_comb begin
    case (csr_wdata_op)
      2'b01:   w_wval = w_old | w_src;
      2'b10:   w_wval = w_old & ~w_src;
      default: w_wval = w_src;
    endcase
  end

  // Interrupts are level-sensitive: nothing is latched until the trap is actually taken.
  assign w_irq_ext = r_mie_b & w_meip & r_meie;
  assign w_irq_tmr = r_mie_b & w_mtip & r_mtie;
  assign w_trap    = !rst & commit_valid &
                     (w_irq_ext | w_irq_tmr | invalid_instruction | ebreak | ecall);
  assign w_mret_go = !rst & commit_valid & mret & !w_trap;
  assign w_we      = csr_en & commit_valid & !w_trap;
  assign w_retire  = commit_valid & !w_trap;

  always_comb begin
    if (w_irq_ext)                w_cause = 32'h8000_000B;
    else if (w_irq_tmr)           w_cause = 32'h8000_0007;
    else if (invalid_instruction) w_cause = 32'h0000_0002;
    else if (ebreak)              w_cause = 32'h0000_0003;
    else                          w_cause = 32'h0000_000B;
  end

  assign trap_taken  = w_trap;
  assign redirect    = w_trap | w_mret_go;
  assign redirect_pc = w_trap    ? {r_mtvec, 2'b00} :
                       w_mret_go ? {r_mepc, 2'b00}  : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext_sync <= '0;
      r_tmr_sync <= '0;
    end else begin
      r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], ext_irq};
      r_tmr_sync <= {r_tmr_sync[SYNC_STAGES-2:0], timer_irq};
    end
  end

  // Trap/mret updates are placed after the CSR write so they win on overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie_b    <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC[31:2];
      r_mscratch <= 32'h0;
      r_mepc     <= 30'h0;
      r_mcause   <= 32'h0;
    end else begin
      if (w_we) begin
        case (csr_addr)
          A_MSTATUS: begin
            r_mie_b <= w_wval[3];
            r_mpie  <= w_wval[7];
          end
          A_MIE: begin
            r_meie <= w_wval[11];
            r_mtie <= w_wval[7];
          end
          A_MTVEC:    r_mtvec    <= w_wval[31:2];
          A_MSCRATCH: r_mscratch <= w_wval;
          A_MEPC:     r_mepc     <= w_wval[31:2];
          A_MCAUSE:   r_mcause   <= w_wval;
          default: ;
        endcase
      end
      if (w_trap) begin
        r_mepc   <= commit_pc[31:2];
        r_mcause <= w_cause;
        r_mpie   <= r_mie_b;
        r_mie_b  <= 1'b0;
      end else if (w_mret_go) begin
        r_mie_b <= r_mpie;
        r_mpie  <= 1'b1;
      end
    end
  end

  // A write to either half replaces that cycle's increment of the whole counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
    end else begin
      if (w_we && csr_addr == A_MCYCLE)       r_mcycle[31:0]  <= w_wval;
      else if (w_we && csr_addr == A_MCYCLEH) r_mcycle[63:32] <= w_wval;
      else                                    r_mcycle        <= r_mcycle + 64'd1;

      if (w_we && csr_addr == A_MINSTRET)       r_minstret[31:0]  <= w_wval;
      else if (w_we && csr_addr == A_MINSTRETH) r_minstret[63:32] <= w_wval;
      else if (w_retire)                        r_minstret        <= r_minstret + 64'd1;
    end
  end

endmodule
